// File: rtl/key_pkg.sv
// Shared definitions for key-handling blocks: debounce FSM state encoding and
// default timing constants for a 50 MHz system clock.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 20 ms
    localparam int LONG_CYCLES_DEF     = 50_000_000; // 1 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so an idle-high input does not look active coming out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronised key level qualified by a stable-time
// counter, with press/release/long-press strobes and a press-toggled level.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | key stably released
// PRESS_DB   | key seen low, waiting for it to stay low
// PRESSED    | key stably pressed, hold timer running
// RELEASE_DB | key seen high, waiting for it to stay high
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_value,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic key_toggle
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("key_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic              key_sync;
    key_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;
    logic [HOLD_W-1:0] hold_next;
    logic              long_hit;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (key),
        .q     (key_sync)
    );

    // Hold timer saturates so a very long press never wraps into a second long_pulse.
    always_comb begin
        hold_next = hold_cnt;
        if (hold_cnt != HOLD_LAST) begin
            hold_next = hold_cnt + 1'b1;
        end
        long_hit = (hold_cnt == HOLD_LAST) && !long_done;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            key_value     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            key_toggle    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state  <= PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (key_sync) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        key_value   <= 1'b0;
                        press_pulse <= 1'b1;
                        key_toggle  <= ~key_toggle;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    hold_cnt <= hold_next;
                    if (long_hit) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end
                    if (key_sync) begin
                        state  <= RELEASE_DB;
                        db_cnt <= '0;
                    end
                end
                RELEASE_DB: begin
                    // A qualifying release wins over a coincident long press.
                    if (key_sync && db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        key_value     <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        hold_cnt <= hold_next;
                        if (long_hit) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end
                        if (!key_sync) begin
                            state  <= PRESSED;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing (16 / 64 cycles):
// clean press, bounce, long press, release glitch, toggle and reset mid-press.
module tb_key_debounce;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key;
    logic key_value;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic key_toggle;

    int cyc = 0;
    int press_n = 0, rel_n = 0, long_n = 0;
    int press_cyc = 0, rel_cyc = 0, long_cyc = 0;
    int total = 0, bad = 0;

    always #5 sys_clk = ~sys_clk;

    key_debounce #(
        .DEBOUNCE_CYCLES (16),
        .LONG_CYCLES     (64)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .key           (key),
        .key_value     (key_value),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .key_toggle    (key_toggle)
    );

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Strobes are sampled half a cycle after the edge that launched them.
    always @(negedge sys_clk) begin
        if (press_pulse) begin
            press_n   = press_n + 1;
            press_cyc = cyc;
        end
        if (release_pulse) begin
            rel_n   = rel_n + 1;
            rel_cyc = cyc;
        end
        if (long_pulse) begin
            long_n   = long_n + 1;
            long_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        int t0, t1, p0, r0, l0;

        sys_rst_n = 1'b0;
        key       = 1'b1;
        wait_cyc(3);
        check("rst_key_value", key_value, 1);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_long", long_pulse, 0);
        check("rst_toggle", key_toggle, 0);
        sys_rst_n = 1'b1;
        wait_cyc(5);

        // clean press held 30 cycles
        p0 = press_n; r0 = rel_n; l0 = long_n;
        key = 1'b0; t0 = cyc;
        wait_cyc(25);
        check("clean_press_count", press_n - p0, 1);
        check("clean_press_latency", press_cyc - t0, 19);
        check("clean_key_value_low", key_value, 0);
        check("clean_toggle", key_toggle, 1);
        wait_cyc(5);
        key = 1'b1; t1 = cyc;
        wait_cyc(25);
        check("clean_release_count", rel_n - r0, 1);
        check("clean_release_latency", rel_cyc - t1, 19);
        check("clean_key_value_high", key_value, 1);
        check("clean_no_long", long_n - l0, 0);

        // bounce: 5 low / 3 high, four times
        p0 = press_n; r0 = rel_n;
        repeat (4) begin
            key = 1'b0; wait_cyc(5);
            key = 1'b1; wait_cyc(3);
        end
        wait_cyc(30);
        check("bounce_no_press", press_n - p0, 0);
        check("bounce_no_release", rel_n - r0, 0);
        check("bounce_key_value", key_value, 1);
        check("bounce_toggle", key_toggle, 1);

        // long press held 100 cycles
        p0 = press_n; r0 = rel_n; l0 = long_n;
        key = 1'b0; t0 = cyc;
        wait_cyc(100);
        check("long_press_count", press_n - p0, 1);
        check("long_count", long_n - l0, 1);
        check("long_delay", long_cyc - press_cyc, 64);
        check("long_toggle", key_toggle, 0);
        key = 1'b1;
        wait_cyc(30);
        check("long_no_repeat", long_n - l0, 1);
        check("long_release_count", rel_n - r0, 1);

        // release glitch: 8 high cycles while pressed
        p0 = press_n; r0 = rel_n; l0 = long_n;
        key = 1'b0;
        wait_cyc(30);
        check("glitch_press_count", press_n - p0, 1);
        key = 1'b1; wait_cyc(8);
        key = 1'b0; wait_cyc(20);
        check("glitch_no_release", rel_n - r0, 0);
        check("glitch_key_value", key_value, 0);
        check("glitch_toggle", key_toggle, 1);
        check("glitch_single_press", press_n - p0, 1);
        key = 1'b1;
        wait_cyc(30);
        check("glitch_final_release", rel_n - r0, 1);
        check("glitch_no_long", long_n - l0, 0);

        // three presses from reset: toggle 1, 0, 1; reset during the third
        sys_rst_n = 1'b0;
        wait_cyc(2);
        check("t3_rst_toggle", key_toggle, 0);
        sys_rst_n = 1'b1;
        wait_cyc(3);
        key = 1'b0; wait_cyc(25);
        check("t3_toggle_1", key_toggle, 1);
        key = 1'b1; wait_cyc(25);
        key = 1'b0; wait_cyc(25);
        check("t3_toggle_2", key_toggle, 0);
        key = 1'b1; wait_cyc(25);
        key = 1'b0; wait_cyc(25);
        check("t3_toggle_3", key_toggle, 1);
        r0 = rel_n; p0 = press_n;
        sys_rst_n = 1'b0;
        wait_cyc(2);
        check("mid_rst_key_value", key_value, 1);
        check("mid_rst_toggle", key_toggle, 0);
        check("mid_rst_press", press_pulse, 0);
        check("mid_rst_release", release_pulse, 0);
        check("mid_rst_long", long_pulse, 0);
        sys_rst_n = 1'b1; t0 = cyc;
        wait_cyc(25);
        check("mid_rst_no_release", rel_n - r0, 0);
        check("requal_press_count", press_n - p0, 1);
        check("requal_latency", press_cyc - t0, 19);
        check("requal_key_value", key_value, 0);
        key = 1'b1;
        wait_cyc(25);
        check("requal_release", rel_n - r0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1_000_000, stable-level qualification time in sys_clk cycles (20 ms at 50 MHz).
REQ-002 Parameter: LONG_CYCLES, 50_000_000, press duration in sys_clk cycles that qualifies a long press (1 s at 50 MHz).
REQ-003 Port: sys_clk  input  1  single system clock, all logic on rising edge.
REQ-004 Port: sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: key  input  1  raw push-button, asynchronous to sys_clk, high when released, low when pressed.
REQ-006 Port: key_value  output  1  debounced key level, same polarity as key; drives the LED stage directly.
REQ-007 Port: press_pulse  output  1  one-cycle strobe on qualified press.
REQ-008 Port: release_pulse  output  1  one-cycle strobe on qualified release.
REQ-009 Port: long_pulse  output  1  one-cycle strobe when a press has lasted LONG_CYCLES.
REQ-010 Port: key_toggle  output  1  level that inverts on every qualified press.

Function
REQ-011 key SHALL pass through a two-flop synchronizer before any other use; key_sync denotes its output.
REQ-012 The FSM SHALL have states IDLE (stable released), PRESS_DB, PRESSED (stable pressed), RELEASE_DB.
REQ-013 IDLE: key_sync=0 -> PRESS_DB with debounce counter cleared to 0.
REQ-014 PRESS_DB: key_sync=1 -> IDLE, counter cleared, no output change (bounce rejected).
REQ-015 PRESS_DB: counter increments each cycle key_sync=0; when counter=DEBOUNCE_CYCLES-1 with key_sync=0 -> PRESSED, key_value<=0, press_pulse<=1 for exactly one cycle, key_toggle inverts, hold counter cleared.
REQ-016 PRESSED: hold counter increments each cycle, saturating at LONG_CYCLES-1; long_pulse asserts for one cycle on reaching LONG_CYCLES-1, at most once per press.
REQ-017 PRESSED: key_sync=1 -> RELEASE_DB with debounce counter cleared.
REQ-018 RELEASE_DB: key_sync=0 -> PRESSED, counter cleared, no pulse, key_toggle unchanged; hold counter keeps counting in RELEASE_DB and is not cleared.
REQ-019 RELEASE_DB: counter=DEBOUNCE_CYCLES-1 with key_sync=1 -> IDLE, key_value<=1, release_pulse<=1 for one cycle.
REQ-020 Press latency: key falling edge to press_pulse = 2 sync cycles + DEBOUNCE_CYCLES + 1 register cycle when key is clean.
REQ-021 All outputs SHALL be registered; press_pulse, release_pulse, long_pulse never assert in the same cycle except long_pulse with nothing else.
REQ-022 Counter widths SHALL be $clog2 of their maximum count; counters never wrap.
REQ-023 DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES are required; violation is flagged by a simulation-time error.

Reset
REQ-024 On sys_rst_n=0: state IDLE, synchronizer flops 1, counters 0, key_value 1, all pulses 0, key_toggle 0.
REQ-025 Reset mid-press SHALL abort without emitting release_pulse; after deassertion a still-pressed key re-qualifies through PRESS_DB.

Structure
REQ-026 State encodings and the default cycle constants SHALL live in shared package key_pkg for reuse by other key-handling blocks.
REQ-027 The synchronizer SHALL be a separate sub-module sync_2ff (reset value parameterised, here 1).

Verification (DEBOUNCE_CYCLES=16, LONG_CYCLES=64)
REQ-028 Clean press held 30 cycles then released -> one press_pulse 19 cycles after falling edge, key_value 0, one release_pulse after release, no long_pulse.
REQ-029 Bounce: key low 5 cycles, high 3, repeated 4 times, then high -> no pulses, key_value stays 1.
REQ-030 Press held 100 cycles -> press_pulse, then exactly one long_pulse 64 cycles later, no repeat.
REQ-031 Release glitch: while pressed, key high 8 cycles then low again -> no release_pulse, key_value stays 0, key_toggle unchanged.
REQ-032 Three clean presses -> key_toggle sequence 1,0,1; reset asserted during third press -> all outputs at reset values, no release_pulse.
